// File: rtl/traffic_injector.sv
// Synthetic NoC traffic source: paces packets by Gap, picks a destination by Mode,
// and runs a req/grant handshake with the downstream router until a quota is met.
`timescale 1ns/1ps
module traffic_injector #(
  parameter logic [5:0]  ROUTER_ID   = 6'b010_000,
  parameter int          MESH_X      = 3,
  parameter int          MESH_Y      = 3,
  parameter int          packetwidth = 56,
  parameter int          ID_W        = 10,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Enable,
  input  logic [1:0]             Mode,
  input  logic [5:0]             FixedDest,
  input  logic [15:0]            Gap,
  input  logic [15:0]            MaxPkts,
  input  logic                   DnStrFull,
  input  logic                   GntDnStr,
  output logic                   ReqDnStr,
  output logic [packetwidth-1:0] PacketOut,
  output logic [15:0]            SentCount,
  output logic                   Done
);

  typedef enum logic [2:0] {
    S_IDLE, S_GAP, S_PKT_PREP, S_SEND_REQ, S_WAIT_GRANT, S_DONE
  } state_e;

  localparam logic [1:0] MODE_RANDOM    = 2'b01;
  localparam logic [1:0] MODE_TRANSPOSE = 2'b10;
  localparam logic [3:0] MESH_X_L       = 4'(MESH_X);
  localparam logic [3:0] MESH_Y_L       = 4'(MESH_Y);

  state_e                 state_q, state_d;
  logic [15:0]            gap_cnt_q, gap_cnt_d;
  logic [15:0]            cyc_q, lfsr_q;
  logic [15:0]            sent_q, sent_d, sent_inc;
  logic [ID_W-1:0]        pkt_id_q, pkt_id_d;
  logic [packetwidth-1:0] pkt_q, pkt_d, pkt_new;
  logic [5:0]             cand;
  logic                   cand_ok;
  logic                   lfsr_fb;

  assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign sent_inc = (sent_q == 16'hFFFF) ? sent_q : sent_q + 16'd1;

  always_comb begin
    case (Mode)
      MODE_RANDOM:    cand = {lfsr_q[2:0], lfsr_q[5:3]};
      MODE_TRANSPOSE: cand = {ROUTER_ID[2:0], ROUTER_ID[5:3]};
      default:        cand = FixedDest;
    endcase
    cand_ok = ({1'b0, cand[5:3]} < MESH_X_L) && ({1'b0, cand[2:0]} < MESH_Y_L)
              && (cand != ROUTER_ID);
  end

  always_comb begin
    pkt_new                = '0;
    pkt_new[15:0]          = cyc_q;
    pkt_new[21:16]         = cand;
    pkt_new[27:22]         = ROUTER_ID;
    pkt_new[27+ID_W:28]    = pkt_id_q;
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      gap_cnt_q <= '0;
      cyc_q     <= '0;
      lfsr_q    <= LFSR_SEED;
      sent_q    <= '0;
      pkt_id_q  <= '0;
      pkt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      cyc_q     <= cyc_q + 16'd1;
      lfsr_q    <= {lfsr_q[14:0], lfsr_fb};
      sent_q    <= sent_d;
      pkt_id_q  <= pkt_id_d;
      pkt_q     <= pkt_d;
    end
  end

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    sent_d    = sent_q;
    pkt_id_d  = pkt_id_q;
    pkt_d     = pkt_q;
    case (state_q)
      S_IDLE: begin
        if (Enable) begin
          state_d   = S_GAP;
          gap_cnt_d = '0;
        end
      end
      S_GAP: begin
        if (!Enable)               state_d   = S_IDLE;
        else if (gap_cnt_q == Gap) state_d   = S_PKT_PREP;
        else                       gap_cnt_d = gap_cnt_q + 16'd1;
      end
      S_PKT_PREP: begin
        // Diagonal nodes have no transpose partner; random misses retry next cycle.
        if (Mode == MODE_TRANSPOSE && cand == ROUTER_ID) begin
          state_d = S_IDLE;
        end else if (Mode != MODE_RANDOM || cand_ok) begin
          pkt_d   = pkt_new;
          state_d = S_SEND_REQ;
        end
      end
      S_SEND_REQ: begin
        if (!DnStrFull) state_d = S_WAIT_GRANT;
      end
      S_WAIT_GRANT: begin
        if (GntDnStr) begin
          pkt_id_d = pkt_id_q + 1'b1;
          sent_d   = sent_inc;
          if (MaxPkts != 16'd0 && sent_inc == MaxPkts) begin
            state_d = S_DONE;
          end else if (Enable) begin
            state_d   = S_GAP;
            gap_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ReqDnStr = (state_q == S_WAIT_GRANT);
    Done     = (state_q == S_DONE);
  end

  assign PacketOut = pkt_q;
  assign SentCount = sent_q;

endmodule

// File: tb/tb_traffic_injector.sv
// Self-checking bench for traffic_injector: scoreboard of expected packets and
// request timing, plus a diagonal-node instance that must never request.
`timescale 1ns/1ps
module tb_traffic_injector;

  localparam logic [5:0] RID  = 6'b010_000;
  localparam logic [5:0] DEST = 6'b000_010;
  localparam int         PW   = 56;
  localparam int         IDW  = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [5:0]    fixed_dest = DEST;
  logic [15:0]   gap = '0;
  logic [15:0]   max_pkts = '0;
  logic          full = 1'b0;
  logic          gnt = 1'b0;
  logic          req, done;
  logic [PW-1:0] pkt;
  logic [15:0]   sent;
  logic          diag_req, diag_done;
  logic [PW-1:0] diag_pkt;
  logic [15:0]   diag_sent;

  int compared   = 0;
  int mismatched = 0;
  int unsigned edge_n = 0;
  int diag_req_hi = 0;

  typedef struct {
    logic [IDW-1:0] id;
    logic [5:0]     dest;
    int unsigned    rise;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  traffic_injector u_dut (
    .clk(clk), .reset(rst_n), .Enable(enable), .Mode(mode), .FixedDest(fixed_dest),
    .Gap(gap), .MaxPkts(max_pkts), .DnStrFull(full), .GntDnStr(gnt),
    .ReqDnStr(req), .PacketOut(pkt), .SentCount(sent), .Done(done)
  );

  traffic_injector #(.ROUTER_ID(6'b011_011)) u_diag (
    .clk(clk), .reset(rst_n), .Enable(enable), .Mode(2'b10), .FixedDest(fixed_dest),
    .Gap(gap), .MaxPkts(max_pkts), .DnStrFull(1'b0), .GntDnStr(gnt),
    .ReqDnStr(diag_req), .PacketOut(diag_pkt), .SentCount(diag_sent), .Done(diag_done)
  );

  // Edge number since reset release; the DUT cycle counter before edge n reads n-1.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;

  always @(posedge clk)
    if (diag_req === 1'b1) diag_req_hi <= diag_req_hi + 1;

  function automatic logic [PW-1:0] mk_pkt(input logic [IDW-1:0] id, input logic [5:0] dest,
                                           input logic [15:0] ts);
    logic [PW-1:0] p;
    p        = '0;
    p[15:0]  = ts;
    p[21:16] = dest;
    p[27:22] = RID;
    p[37:28] = id;
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    gnt = 1'b0; full = 1'b0; enable = 1'b0;
    mode = 2'b00; fixed_dest = DEST; gap = '0; max_pkts = '0;
    repeat (2) step();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (req === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    compared++; if (req !== 1'b0) begin mismatched++; $display("FAIL reset_req got %b want 0", req); end
    compared++; if (pkt !== '0) begin mismatched++; $display("FAIL reset_pkt got %h want 0", pkt); end
    compared++; if (sent !== 16'd0) begin mismatched++; $display("FAIL reset_sent got %0d want 0", sent); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done got %b want 0", done); end
  endtask

  task automatic test_fixed_quota();
    bit ok;
    exp_t e;
    int hi;
    do_reset();
    fixed_dest = DEST; max_pkts = 16'd3; enable = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back('{id: IDW'(i), dest: DEST, rise: 4 + 4 * i});
    release_reset();
    for (int i = 0; i < 3; i++) begin
      wait_req(50, ok);
      e = sb.pop_front();
      compared++;
      if (!ok || edge_n != e.rise) begin
        mismatched++; $display("FAIL fixed_rise[%0d] got edge %0d (ok=%0b) want %0d", i, edge_n, ok, e.rise);
      end
      compared++;
      if (pkt !== mk_pkt(e.id, e.dest, 16'(e.rise - 2))) begin
        mismatched++; $display("FAIL fixed_pkt[%0d] got %h want %h", i, pkt, mk_pkt(e.id, e.dest, 16'(e.rise - 2)));
      end
      gnt = 1'b1; step(); gnt = 1'b0;
      compared++; if (req !== 1'b0) begin mismatched++; $display("FAIL fixed_req_drop[%0d] got %b want 0", i, req); end
    end
    compared++; if (sent !== 16'd3) begin mismatched++; $display("FAIL fixed_sent got %0d want 3", sent); end
    compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL fixed_done got %b want 1", done); end
    gnt = 1'b1; hi = 0;
    repeat (10) begin step(); if (req !== 1'b0 || done !== 1'b1) hi++; end
    gnt = 1'b0;
    compared++; if (hi != 0) begin mismatched++; $display("FAIL done_hold got %0d bad cycles want 0", hi); end
    compared++; if (sent !== 16'd3) begin mismatched++; $display("FAIL done_sent got %0d want 3", sent); end
  endtask

  task automatic test_gap_latency();
    bit ok;
    exp_t e;
    do_reset();
    gap = 16'd5; enable = 1'b1;
    sb.push_back('{id: 10'd0, dest: DEST, rise: 9});
    sb.push_back('{id: 10'd1, dest: DEST, rise: 18});
    release_reset();
    for (int i = 0; i < 2; i++) begin
      wait_req(50, ok);
      e = sb.pop_front();
      compared++;
      if (!ok || edge_n != e.rise) begin
        mismatched++; $display("FAIL gap_rise[%0d] got edge %0d (ok=%0b) want %0d", i, edge_n, ok, e.rise);
      end
      compared++;
      if (pkt !== mk_pkt(e.id, e.dest, 16'(e.rise - 2))) begin
        mismatched++; $display("FAIL gap_pkt[%0d] got %h want %h", i, pkt, mk_pkt(e.id, e.dest, 16'(e.rise - 2)));
      end
      gnt = 1'b1; step(); gnt = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int bad;
    logic [PW-1:0] exp_pkt;
    do_reset();
    full = 1'b1; enable = 1'b1;
    exp_pkt = mk_pkt(10'd0, DEST, 16'd2);
    release_reset();
    bad = 0;
    repeat (13) begin step(); if (req !== 1'b0) bad++; end
    compared++; if (bad != 0) begin mismatched++; $display("FAIL full_hold got %0d req cycles want 0", bad); end
    full = 1'b0;
    step();
    compared++;
    if (req !== 1'b1 || edge_n != 14) begin
      mismatched++; $display("FAIL full_release got req=%b edge %0d want 1 at 14", req, edge_n);
    end
    compared++; if (pkt !== exp_pkt) begin mismatched++; $display("FAIL full_pkt got %h want %h", pkt, exp_pkt); end
    enable = 1'b0; mode = 2'b01; fixed_dest = 6'b001_001; gap = 16'd7;
    bad = 0;
    repeat (6) begin step(); if (req !== 1'b1 || pkt !== exp_pkt) bad++; end
    compared++; if (bad != 0) begin mismatched++; $display("FAIL req_stable got %0d unstable cycles want 0", bad); end
    gnt = 1'b1; step();
    compared++; if (sent !== 16'd1) begin mismatched++; $display("FAIL full_sent got %0d want 1", sent); end
    bad = 0;
    repeat (10) begin step(); if (req !== 1'b0) bad++; end
    gnt = 1'b0;
    compared++; if (bad != 0) begin mismatched++; $display("FAIL idle_after_grant got %0d req cycles want 0", bad); end
    compared++; if (sent !== 16'd1) begin mismatched++; $display("FAIL stray_grant got sent %0d want 1", sent); end
  endtask

  task automatic test_random();
    bit ok;
    logic [5:0] d;
    logic [8:0] seen;
    do_reset();
    mode = 2'b01; enable = 1'b1;
    release_reset();
    seen = '0;
    for (int i = 0; i < 1000; i++) begin
      wait_req(300, ok);
      if (!ok) begin
        compared++; mismatched++;
        $display("FAIL random_timeout got no request for packet %0d want request", i);
        break;
      end
      d = pkt[21:16];
      compared++;
      if (d[5:3] >= 3'd3 || d[2:0] >= 3'd3 || d == RID) begin
        mismatched++; $display("FAIL random_dest[%0d] got %b want legal non-self", i, d);
      end else begin
        seen[int'(d[5:3]) * 3 + int'(d[2:0])] = 1'b1;
      end
      compared++;
      if (pkt[37:28] !== IDW'(i)) begin
        mismatched++; $display("FAIL random_id[%0d] got %0d want %0d", i, pkt[37:28], IDW'(i));
      end
      gnt = 1'b1; step(); gnt = 1'b0;
    end
    compared++; if (seen !== 9'b110_111_111) begin mismatched++; $display("FAIL random_cover got %b want 110111111", seen); end
    compared++; if (sent !== 16'd1000) begin mismatched++; $display("FAIL random_sent got %0d want 1000", sent); end
  endtask

  task automatic test_transpose();
    bit ok;
    do_reset();
    mode = 2'b10; fixed_dest = 6'b001_001; enable = 1'b1;
    release_reset();
    wait_req(20, ok);
    compared++;
    if (!ok || edge_n != 4) begin
      mismatched++; $display("FAIL transpose_rise got edge %0d (ok=%0b) want 4", edge_n, ok);
    end
    compared++;
    if (pkt !== mk_pkt(10'd0, DEST, 16'd2)) begin
      mismatched++; $display("FAIL transpose_pkt got %h want %h", pkt, mk_pkt(10'd0, DEST, 16'd2));
    end
    gnt = 1'b1; step(); gnt = 1'b0;
    repeat (50) step();
    compared++; if (diag_req_hi != 0) begin mismatched++; $display("FAIL diag_req got %0d req cycles want 0", diag_req_hi); end
    compared++; if (diag_sent !== 16'd0) begin mismatched++; $display("FAIL diag_sent got %0d want 0", diag_sent); end
    compared++;
    if (diag_pkt !== '0 || diag_done !== 1'b0) begin
      mismatched++; $display("FAIL diag_idle got pkt %h done %b want 0 0", diag_pkt, diag_done);
    end
  endtask

  task automatic test_reset_mid_request();
    bit ok;
    do_reset();
    enable = 1'b1;
    release_reset();
    wait_req(20, ok);
    gnt = 1'b1; step(); gnt = 1'b0;
    wait_req(20, ok);
    compared++;
    if (!ok || pkt[37:28] !== 10'd1 || sent !== 16'd1) begin
      mismatched++; $display("FAIL midreq_setup got ok=%0b id %0d sent %0d want 1 1 1", ok, pkt[37:28], sent);
    end
    #2 rst_n = 1'b0;
    #1;
    compared++; if (req !== 1'b0) begin mismatched++; $display("FAIL midreq_req got %b want 0", req); end
    compared++; if (pkt !== '0) begin mismatched++; $display("FAIL midreq_pkt got %h want 0", pkt); end
    compared++; if (sent !== 16'd0) begin mismatched++; $display("FAIL midreq_sent got %0d want 0", sent); end
    release_reset();
    wait_req(20, ok);
    compared++;
    if (!ok || edge_n != 4 || pkt !== mk_pkt(10'd0, DEST, 16'd2)) begin
      mismatched++; $display("FAIL post_reset_pkt got %h at edge %0d want %h at 4", pkt, edge_n, mk_pkt(10'd0, DEST, 16'd2));
    end
    gnt = 1'b1; step(); gnt = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fixed_quota();
    test_gap_latency();
    test_backpressure();
    test_random();
    test_transpose();
    test_reset_mid_request();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/traffic_injector.md
TRAFFIC_INJECTOR -- requirements
Module: traffic_injector

Interface
REQ-001 Parameters SHALL be (name, default, meaning), one per line:
- ROUTER_ID, 6'b010_000, source node ID {x[5:3], y[2:0]}.
- MESH_X, 3, mesh columns (1..8).
- MESH_Y, 3, mesh rows (1..8).
- packetwidth, 56, PacketOut width; must be at least 28+ID_W.
- ID_W, 10, PacketID width.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

REQ-002 Ports SHALL be (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all state updates on its rising edge.
- reset, in, 1, asynchronous, active-low reset.
- Enable, in, 1, injection enable.
- Mode, in, 2, destination mode: 00 fixed, 01 uniform random, 10 transpose, 11 reserved (treated as 00).
- FixedDest, in, 6, destination used in fixed mode.
- Gap, in, 16, idle cycles between packets.
- MaxPkts, in, 16, packet quota; 0 means unlimited.
- DnStrFull, in, 1, downstream FIFO full.
- GntDnStr, in, 1, grant from downstream router.
- ReqDnStr, out, 1, request to downstream router.
- PacketOut, out, packetwidth, packet data.
- SentCount, out, 16, count of granted packets.
- Done, out, 1, quota reached.

Function
REQ-003 PacketOut SHALL be zero-extended {PacketID, ROUTER_ID, DestID, Timestamp}, with these fields:
- Timestamp at bits [15:0].
- DestID at [21:16].
- SrcID at [27:22].
- PacketID at [27+ID_W:28].
- All remaining upper bits zero.

REQ-004 A free-running 16-bit cycle counter SHALL increment every clock and wrap from FFFF to 0000.

REQ-005 A 16-bit Fibonacci LFSR with taps 16,14,13,11 SHALL advance every clock.

REQ-006 The state machine SHALL have six states: IDLE, GAP, PKT_PREP, SEND_REQ, WAIT_GRANT, DONE.

REQ-007 IDLE: Enable=1 SHALL move to GAP with the gap counter cleared to 0; otherwise the FSM stays in IDLE.

REQ-008 GAP behaviour SHALL be:
- Enable=0 moves to IDLE.
- Otherwise, counter==Gap moves to PKT_PREP.
- Otherwise the counter increments.

REQ-009 PKT_PREP SHALL select the candidate DestID by Mode:
- Fixed mode: FixedDest.
- Random mode: {lfsr[2:0], lfsr[5:3]}.
- Transpose mode: {ROUTER_ID[2:0], ROUTER_ID[5:3]}.

REQ-010 In PKT_PREP, a random candidate that has x≥MESH_X, y≥MESH_Y, or equals ROUTER_ID SHALL be rejected, and the FSM stays in PKT_PREP for the next cycle.

REQ-011 In transpose mode, a diagonal node (candidate equals ROUTER_ID) SHALL return to IDLE and never request.

REQ-012 On a valid candidate, PKT_PREP SHALL latch PacketOut, taking the Timestamp as the current pre-increment cycle counter value, and move to SEND_REQ.

REQ-013 SEND_REQ: DnStrFull=0 SHALL set ReqDnStr=1 and move to WAIT_GRANT; DnStrFull=1 holds the FSM in SEND_REQ.

REQ-014 While ReqDnStr=1, ReqDnStr and PacketOut SHALL remain stable until the grant.
- Enable=0 and changes on Mode, FixedDest or Gap do not abort an outstanding request.

REQ-015 WAIT_GRANT on GntDnStr=1 SHALL, on that edge:
- Clear ReqDnStr.
- Increment PacketID (wraps at 2^ID_W).
- Increment SentCount (saturates at FFFF).
- Go to DONE if MaxPkts≠0 and the new SentCount==MaxPkts; else to GAP if Enable=1; else to IDLE.

REQ-016 GntDnStr SHALL be ignored in every state other than WAIT_GRANT.

REQ-017 DONE SHALL hold Done=1 and ReqDnStr=0 until reset.

REQ-018 Latency SHALL be as follows, with Gap=G, valid destination and DnStrFull=0:
- ReqDnStr rises on edge G+4, counting the edge that samples Enable=1 in IDLE as edge 1.
- After a grant on edge k, the next ReqDnStr rises on edge k+G+3.

REQ-019 Mode, FixedDest, Gap and MaxPkts SHALL be sampled only in the states that use them; they need no synchronous qualifiers.

Reset
REQ-020 reset=0 SHALL asynchronously force the following, including mid-request (ReqDnStr drops without waiting for a grant):
- State to IDLE.
- ReqDnStr=0, Done=0, PacketOut=0.
- PacketID=0, SentCount=0.
- Gap counter=0, cycle counter=0.
- LFSR=LFSR_SEED.

REQ-021 After reset deasserts, operation SHALL begin at the first rising edge at which reset=1, from the state given in REQ-020.

Verification
REQ-022 Fixed mode, FixedDest=6'b000_010, Gap=0, MaxPkts=3, grant one cycle after each request -> three packets with PacketID 0,1,2, SrcID 010_000, DestID 000_010; SentCount=3; Done=1; ReqDnStr stays 0 afterwards.

REQ-023 Gap=5, Enable raised -> ReqDnStr rises on edge 9; with an immediate grant, the next rise is 8 edges after the grant edge.

REQ-024 DnStrFull=1 held for 10 cycles with a packet prepared -> ReqDnStr stays 0 and the FSM stays in SEND_REQ; on release, ReqDnStr rises on the next edge.

REQ-025 Random mode, MESH_X=MESH_Y=3, 1000 packets -> every DestID has x,y<3 and DestID≠ROUTER_ID; all 8 legal destinations are seen.

REQ-026 Transpose mode with ROUTER_ID=011_011 -> ReqDnStr is never asserted and SentCount=0; with ROUTER_ID=010_000 -> DestID=000_010.

REQ-027 reset pulsed low while ReqDnStr=1 -> ReqDnStr=0, PacketOut=0 and SentCount=0 asynchronously; the next packet after reset carries PacketID=0.
